wormy_matrix_scan: RTL and testbench
====================================

# wormy_matrix_scan

Drives the 4x4 LED matrix from the `arena_on` cell vector produced by the wormy game core. It sits directly downstream of the game core.

- **Frame capture:** once per frame it snapshots `arena_on` into a frame buffer, so a game update landing mid-scan never tears the image.
- **Row scan:** it time-multiplexes the four rows with active-low row strobes and active-high column drives.
- **Brightness:** a 3-bit PWM duty input sets display brightness.

## Interface

Parameters:
- `DWELL`, default 64: active cycles per row. Must be a multiple of 8 and at least 8.
- `BLANK`, default 4: all-off cycles before each row. Must be at least 1; used only when `WORMY_SCAN_BLANK_EN` is defined.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `arena_on`  in  16  cell vector from the game core; bit index is {y[1:0], x[1:0]}
- `brightness`  in  3  PWM level; 0 is dimmest (1/8 duty), 7 is full (8/8 duty)
- `row_n`  out  4  row strobes, active-low; `row_n[y]` selects row y
- `col`  out  4  column drives, active-high; `col[x]` lights cell (x, current row)
- `frame_start`  out  1  one-cycle pulse on the first cycle of each frame

## Operation

- **Reset values:** `row_n` = 4'b1111, `col` = 4'b0000, `frame_start` = 0, frame buffer = 16'h0000, latched brightness = 0.
- **Output registers:** all outputs are registered. No combinational path exists from `arena_on` or `brightness` to any output.
- **Per-row phases:**
  - BLANK for `BLANK` cycles: `row_n` = 4'b1111, `col` = 0.
  - ACTIVE for `DWELL` cycles: `row_n` = ~(4'b0001 << row), and `col` = frame_buf[4*row+3 : 4*row] gated by PWM.
- **Row order:** row counter runs 0→1→2→3 and wraps to 0. Wrapping from row 3 ACTIVE back to row 0 is the frame boundary.
- **Frame boundary actions**, on the boundary edge:
  - frame_buf <= `arena_on`
  - latched brightness <= `brightness`
  - `frame_start` is 1 for exactly the following cycle (the first cycle of row 0).
- **PWM rule:**
  - Dwell counter d runs 0..DWELL-1 within ACTIVE.
  - Columns are enabled when d < (bright_latched + 1) * (DWELL/8); otherwise `col` = 0 while `row_n` stays asserted.
  - Compute the threshold at width clog2(DWELL)+1 so that 8*(DWELL/8) does not overflow.
- **Reset release:** the first clock edge with `rst` low is a frame boundary. It captures `arena_on` and pulses `frame_start` in the following cycle.
- **Reset mid-frame:** `rst` asserted at any point forces reset values on that edge. The scan restarts from row 0 after release, and no partial row is displayed.
- **Input changes mid-frame:** changes to `arena_on` or `brightness` mid-frame have no visible effect until the next frame boundary.

## Timing

- **Frame period:** 4*(BLANK+DWELL) cycles with blanking (default 272); 4*DWELL without (default 256).
- **`frame_start` spacing:** exactly one frame period between pulses.
- **Display latency:** a change on `arena_on` in the cycle before a boundary edge is visible in row y at 1 + y*(BLANK+DWELL) + BLANK cycles after that edge. Worst case is one frame period longer.
- **No overlap:** at most one `row_n` bit is low in any cycle. During BLANK all four bits are high.

## Configuration

- **`WORMY_SCAN_BLANK_EN` defined:** the BLANK phase precedes every row, suppressing ghosting from slow row drivers. The frame starts in row 0 BLANK, and `frame_start` coincides with the first blank cycle.
- **`WORMY_SCAN_BLANK_EN` not defined:**
  - The BLANK phase and the `BLANK` parameter are ignored.
  - Rows switch directly from ACTIVE to ACTIVE.
  - `frame_start` coincides with the first ACTIVE cycle of row 0, and frame_buf is already updated in that cycle.

## Test plan

All tests use DWELL=8, BLANK=2, with the macro defined unless noted (frame period 40).

1. **Reset:** hold `rst` 3 cycles, then release with `arena_on`=16'h0011 and `brightness`=7.
   - `frame_start`=1 in cycle 1 after release; `row_n`=4'b1111 for cycles 1-2.
   - Cycles 3-10: `row_n`=4'b1110, `col`=4'b0001. Cycles 13-20: `row_n`=4'b1101, `col`=4'b0001.
   - The next `frame_start` occurs in cycle 41.
2. **PWM:** `brightness`=2, `arena_on`=16'hFFFF.
   - Each ACTIVE row shows `col`=4'hF for 3 cycles, then 4'h0 for 5 cycles, with `row_n` held low for all 8.
3. **Tearing:** change `arena_on` from 16'h0001 to 16'h8000 during row 1 ACTIVE.
   - The rest of the frame still shows 16'h0001.
   - Row 3 shows `col`=4'b1000 only in the next frame.
4. **Reset mid-row:** assert `rst` during row 2 ACTIVE.
   - Next cycle: `row_n`=4'b1111, `col`=0.
   - After release the scan restarts with a `frame_start` and row 0.
5. **Macro undefined:** `brightness`=7, `arena_on`=16'h1111.
   - Frame period is 32 cycles and `row_n` is never 4'b1111 after the first frame starts.
   - Each row shows `col`=4'b0001 for 8 cycles.
6. **Row overlap:** run 10 frames with random `arena_on`/`brightness`.
   - Assert popcount(~`row_n`) ≤ 1 on every cycle.

Source files
------------

// File: rtl/wormy_matrix_scan.sv
// 4x4 LED matrix row scanner with per-frame snapshot and 3-bit PWM brightness.
// Optional per-row blanking is enabled by defining WORMY_SCAN_BLANK_EN.
module wormy_matrix_scan #(
  parameter int DWELL = 64,
  parameter int BLANK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] arena_on,
  input  logic [2:0]  brightness,
  output logic [3:0]  row_n,
  output logic [3:0]  col,
  output logic        frame_start
);

  localparam int TW = $clog2(DWELL) + 1;
  localparam int BW = $clog2(BLANK) + 1;
  localparam int CW = (TW > BW) ? TW : BW;

  typedef enum logic {PH_BLANK, PH_ACTIVE} phase_t;

`ifdef WORMY_SCAN_BLANK_EN
  localparam phase_t ROW_ENTRY = PH_BLANK;
`else
  localparam phase_t ROW_ENTRY = PH_ACTIVE;
`endif

  phase_t        phase, nphase;
  logic [1:0]    row, nrow;
  logic [CW-1:0] cnt, ncnt;
  logic [15:0]   frame_buf, nbuf;
  logic [2:0]    bright, nbright;
  logic          started;
  logic          boundary;
  logic [TW-1:0] thr;
  logic [3:0]    ncol;

  // Outputs are registered from the next-state values, so the frame_start
  // cycle already shows the freshly captured frame.
  always_comb begin
    boundary = !started ||
               (phase == PH_ACTIVE && row == 2'd3 && cnt == CW'(DWELL - 1));
    nphase   = phase;
    nrow     = row;
    ncnt     = cnt;
    nbuf     = frame_buf;
    nbright  = bright;
    if (boundary) begin
      nphase  = ROW_ENTRY;
      nrow    = 2'd0;
      ncnt    = '0;
      nbuf    = arena_on;
      nbright = brightness;
    end else if (phase == PH_BLANK) begin
      if (cnt == CW'(BLANK - 1)) begin
        nphase = PH_ACTIVE;
        ncnt   = '0;
      end else begin
        ncnt = cnt + CW'(1);
      end
    end else if (cnt == CW'(DWELL - 1)) begin
      nphase = ROW_ENTRY;
      nrow   = row + 2'd1;
      ncnt   = '0;
    end else begin
      ncnt = cnt + CW'(1);
    end
    // Threshold is one bit wider than the dwell count so full duty (8/8) fits.
    thr  = TW'({1'b0, nbright} + 4'd1) * TW'(DWELL / 8);
    ncol = (ncnt < CW'(thr)) ? nbuf[{nrow, 2'b00} +: 4] : 4'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      started     <= 1'b0;
      phase       <= PH_BLANK;
      row         <= 2'd0;
      cnt         <= '0;
      frame_buf   <= 16'h0000;
      bright      <= 3'd0;
      row_n       <= 4'b1111;
      col         <= 4'b0000;
      frame_start <= 1'b0;
    end else begin
      started     <= 1'b1;
      phase       <= nphase;
      row         <= nrow;
      cnt         <= ncnt;
      frame_buf   <= nbuf;
      bright      <= nbright;
      frame_start <= boundary;
      row_n       <= (nphase == PH_ACTIVE) ? ~(4'b0001 << nrow) : 4'b1111;
      col         <= (nphase == PH_ACTIVE) ? ncol : 4'b0000;
    end
  end

endmodule

// File: tb/tb_wormy_matrix_scan.sv
// Bench for wormy_matrix_scan: directed sequence plus random frames, checked
// every cycle against a frame-position model (DWELL=8, BLANK=2).
module tb_wormy_matrix_scan;
  localparam int DW  = 8;
  localparam int BLK = 2;
`ifdef WORMY_SCAN_BLANK_EN
  localparam int BL = BLK;
`else
  localparam int BL = 0;
`endif
  localparam int W = BL + DW;
  localparam int P = 4 * W;

  logic        clk;
  logic        rst;
  logic [15:0] arena_on;
  logic [2:0]  brightness;
  logic [3:0]  row_n;
  logic [3:0]  col;
  logic        frame_start;

  wormy_matrix_scan #(.DWELL(DW), .BLANK(BLK)) dut (
    .clk(clk), .rst(rst), .arena_on(arena_on), .brightness(brightness),
    .row_n(row_n), .col(col), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  // Model: position within the frame, snapshot and brightness of this frame.
  int          p = 0;
  bit          mstarted = 0;
  logic [15:0] mbuf = 16'h0;
  int          mb = 0;

  task automatic step();
    logic [3:0] exp_rn, exp_col;
    logic       exp_fs;
    int r, q, d;
    @(posedge clk);
    cyc++;
    if (rst) begin
      mstarted = 0; mbuf = 16'h0; mb = 0; p = 0;
    end else if (!mstarted || p == P - 1) begin
      mstarted = 1; p = 0; mbuf = arena_on; mb = int'(brightness);
    end else begin
      p++;
    end
    exp_rn = 4'b1111; exp_col = 4'b0000; exp_fs = 1'b0;
    if (mstarted) begin
      r = p / W; q = p % W;
      exp_fs = (p == 0);
      if (q >= BL) begin
        d = q - BL;
        exp_rn = ~(4'b0001 << r);
        if (d < (mb + 1) * (DW / 8)) exp_col = mbuf[4*r +: 4];
      end
    end
    #1;
    checks++;
    assert (row_n === exp_rn) else begin
      errors++; $error("FAIL row_n cyc=%0d got %b want %b", cyc, row_n, exp_rn);
    end
    checks++;
    assert (col === exp_col) else begin
      errors++; $error("FAIL col cyc=%0d got %b want %b", cyc, col, exp_col);
    end
    checks++;
    assert (frame_start === exp_fs) else begin
      errors++; $error("FAIL frame_start cyc=%0d got %b want %b", cyc, frame_start, exp_fs);
    end
    checks++;
    assert (($countones(~row_n) <= 1) === 1'b1) else begin
      errors++; $error("FAIL overlap cyc=%0d got row_n=%b want <=1 low", cyc, row_n);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the model is at frame position tgt; bounded by two frames.
  task automatic run_to(input int tgt);
    int k;
    k = 0;
    while (!(mstarted && p == tgt) && k < 2 * P + 4) begin
      step(); k++;
    end
    checks++;
    assert ((mstarted && p == tgt) === 1'b1) else begin
      errors++; $error("FAIL run_to got pos=%0d want %0d", p, tgt);
    end
  endtask

  initial begin
    rst = 1'b1; arena_on = 16'h0011; brightness = 3'd7;
    run(3);
    // Reset release: frame captured and scanned, next frame_start one period later.
    rst = 1'b0;
    run(P + 5);

    // PWM at brightness 2 on a fully lit arena.
    brightness = 3'd2; arena_on = 16'hFFFF;
    run_to(P - 1);
    run(2 * P);

    // Tearing: change mid-frame, must not show until next frame.
    arena_on = 16'h0001;
    run_to(P - 1);
    run_to(W + BL + 2);
    arena_on = 16'h8000;
    run_to(P - 1);
    run(P + 2);

    // Reset during row 2 active, then restart.
    run_to(2 * W + BL + 3);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(P + 4);

    // Random frames.
    for (int i = 0; i < 10 * P; i++) begin
      arena_on   = 16'($urandom);
      brightness = 3'($urandom_range(0, 7));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
